// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one signed mac_unit through an N-element dot product.
// Latency: start->mac_clr 1 cycle, per element 2 + MAC latency, final mac_done->res_valid 1 cycle.
// Backpressure: in_ready only in FEED (and DRAIN); result is held in RESULT until res_ready.
//
// Ports: clk/reset (async active-low); start/cfg_len/busy job control;
// in_valid/in_ready/in_a/in_b operand stream; mac_clr/mac_valid/mac_a/mac_b
// drive the MAC, mac_y/mac_overflow/mac_done return from it;
// res_valid/res_ready/res_data/res_ovf/res_err present the job result.
// Optional build macro MAC_OVF_ABORT_EN: the first overflowing product aborts
// the job with a saturated result and the remaining operand pairs are drained.
module mac_seq_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int LEN_W    = 8,
  parameter int DONE_TMO = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_clr,
  output logic              mac_valid,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_y,
  input  logic              mac_overflow,
  input  logic              mac_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              res_err
);

  localparam int TMO_W = $clog2(DONE_TMO + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
`ifdef MAC_OVF_ABORT_EN
  localparam logic [2:0] S_DRAIN  = 3'd5;
`endif

  logic [2:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic [TMO_W-1:0] tmo_cnt;
  logic             last;

  assign count_inc = count + 1'b1;
  // The element being completed (or drained) is the final one of the job.
  assign last      = (count_inc == len_q);

  assign busy      = (state != S_IDLE);
  assign mac_clr   = (state == S_CLEAR);
  assign res_valid = (state == S_RESULT);
`ifdef MAC_OVF_ABORT_EN
  assign in_ready  = (state == S_FEED) || (state == S_DRAIN);
`else
  assign in_ready  = (state == S_FEED);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      count     <= '0;
      tmo_cnt   <= '0;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      // mac_valid is a single-cycle strobe following each FEED handshake.
      mac_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= cfg_len;
            count    <= '0;
            tmo_cnt  <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_err  <= 1'b0;
            // A zero-length job skips the MAC entirely and reports zero.
            state    <= (cfg_len == '0) ? S_RESULT : S_CLEAR;
          end
        end
        S_CLEAR: state <= S_FEED;
        S_FEED: begin
          if (in_valid) begin
            mac_a     <= in_a;
            mac_b     <= in_b;
            mac_valid <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mac_done) begin
            count   <= count_inc;
            tmo_cnt <= '0;
`ifdef MAC_OVF_ABORT_EN
            if (mac_overflow) begin
              res_ovf  <= 1'b1;
              // Saturate toward the sign of the product that overflowed.
              res_data <= (mac_a[DATA_W-1] ^ mac_b[DATA_W-1]) ?
                          {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
              state    <= last ? S_RESULT : S_DRAIN;
            end else if (last) begin
              res_data <= mac_y;
              state    <= S_RESULT;
            end else begin
              state    <= S_FEED;
            end
`else
            res_ovf <= res_ovf | mac_overflow;
            if (last) begin
              res_data <= mac_y;
              state    <= S_RESULT;
            end else begin
              state    <= S_FEED;
            end
`endif
          end else if (tmo_cnt == TMO_W'(DONE_TMO - 1)) begin
            // DONE_TMO cycles in WAIT without completion: report what the MAC holds.
            res_err  <= 1'b1;
            res_data <= mac_y;
            state    <= S_RESULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
`ifdef MAC_OVF_ABORT_EN
        S_DRAIN: begin
          // Swallow the rest of the job's operands so the source stays aligned.
          if (in_valid) begin
            count <= count_inc;
            if (last) state <= S_RESULT;
          end
        end
`endif
        S_RESULT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
